rx_stat_scheduler: RTL and testbench

//  Accumulates the 18 per-event pulses of the receive statistics vector into CNT_W-bit counters.
//  The counters live in one shared single-port counter array.
//  The array is time-shared between an update engine (read-modify-write, round-robin over sources)
//  and a host read/clear-on-read port. Sits after the rx statistics pulse logic in the rxclk domain.

---
 rtl/rx_stat_pkg.sv | 35 +++
 rtl/rx_stat_scheduler_if.sv | 13 +
 rtl/rx_stat_pend_cnt.sv | 42 ++++
 rtl/rx_stat_scheduler.sv | 165 ++++++++++++++++
 tb/tb_rx_stat_scheduler.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rx_stat_pkg.sv
// Shared constants and types for the receive statistics counter scheduler.
package rx_stat_pkg;

   localparam int NUM_STATS = 18;
   localparam int CNT_W     = 64;
   localparam int PEND_W    = 4;
   localparam int ADDR_W    = 5;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_STATS - 1);
   localparam logic [ADDR_W-1:0] NUM_ADDR  = ADDR_W'(NUM_STATS);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD, ST_WR} state_e;
   typedef enum logic {GNT_ENGINE, GNT_HOST} gnt_e;

   // stat_plus bit positions
   localparam int STAT_FRAME_OK     = 0;
   localparam int STAT_FCS_ERR      = 1;
   localparam int STAT_LEN_ERR      = 2;
   localparam int STAT_ALIGN_ERR    = 3;
   localparam int STAT_MCAST        = 4;
   localparam int STAT_BCAST        = 5;
   localparam int STAT_PAUSE        = 6;
   localparam int STAT_VLAN         = 7;
   localparam int STAT_RUNT         = 8;
   localparam int STAT_JABBER       = 9;
   localparam int STAT_OVERSIZE     = 10;
   localparam int STAT_SZ_64        = 11;
   localparam int STAT_SZ_65_127    = 12;
   localparam int STAT_SZ_128_255   = 13;
   localparam int STAT_SZ_256_511   = 14;
   localparam int STAT_SZ_512_1023  = 15;
   localparam int STAT_SZ_1024_MAX  = 16;
   localparam int STAT_FIFO_OVF     = 17;

endpackage

// File: rtl/rx_stat_scheduler_if.sv
// Host read / clear-on-read port of the statistics counter array.
import rx_stat_pkg::*;

interface rx_stat_scheduler_if;
   logic              host_req;
   logic [ADDR_W-1:0] host_addr;
   logic              host_clr;
   logic              host_ack;
   logic [CNT_W-1:0]  host_rdata;

   modport master (output host_req, host_addr, host_clr, input host_ack, host_rdata);
   modport slave  (input host_req, host_addr, host_clr, output host_ack, host_rdata);
endinterface

// File: rtl/rx_stat_pend_cnt.sv
// One per-source pending event counter; saturates and flags a sticky overflow.
module rx_stat_pend_cnt
   import rx_stat_pkg::*;
(
   input  logic              rxclk,
   input  logic              reset_n,
   input  logic              plus,
   input  logic              gnt,
   output logic [PEND_W-1:0] pend,
   output logic              ovf
);

   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;

   // a grant hands the count to the engine; this cycle's event restarts the count
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (gnt) begin
         pend_d = PEND_W'(plus);
      end else if (plus) begin
         if (pend_q == '1) ovf_d = 1'b1;
         else              pend_d = pend_q + PEND_W'(1);
      end
   end

   // pending count and sticky overflow registers
   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign pend = pend_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/rx_stat_scheduler.sv
// Shared single-port statistics counter array, time-shared between a
// round-robin update engine and a host read/clear-on-read port.
//
//  state | meaning
//  INIT  | clearing array entries 0..NUM_STATS-1, one per cycle
//  IDLE  | arbitrate host vs engine for the next array transaction
//  RD    | read granted entry into a register
//  WR    | engine: write back sum; host: ack, optional clear
module rx_stat_scheduler
   import rx_stat_pkg::*;
(
   input  logic                 rxclk,
   input  logic                 reset_n,
   input  logic [NUM_STATS-1:0] stat_plus,
   rx_stat_scheduler_if.slave   host,
   output logic [NUM_STATS-1:0] pend_ovf,
   output logic                 init_done
);

   logic [PEND_W-1:0] pend [NUM_STATS];
   logic [NUM_STATS-1:0] gnt_vec;
   logic [CNT_W-1:0] mem_q [NUM_STATS];

   state_e            state_q, state_d;
   gnt_e              gnt_src_q, gnt_src_d, last_gnt_q, last_gnt_d;
   logic [ADDR_W-1:0] gnt_addr_q, gnt_addr_d, rr_q, rr_d, init_cnt_q, init_cnt_d;
   logic [PEND_W-1:0] snap_q, snap_d;
   logic [CNT_W-1:0]  rd_q, rd_d, host_rdata_q, host_rdata_d;
   logic              init_done_q, init_done_d;

   logic              cand_vld, host_win, addr_ok, mem_we, host_ack_c;
   logic [ADDR_W-1:0] cand, mem_addr;
   logic [ADDR_W:0]   idx_w;
   logic [CNT_W-1:0]  mem_wdata, mem_rd;

   for (genvar i = 0; i < NUM_STATS; i++) begin : g_pend
      rx_stat_pend_cnt u_pend (
         .rxclk   (rxclk),
         .reset_n (reset_n),
         .plus    (stat_plus[i]),
         .gnt     (gnt_vec[i]),
         .pend    (pend[i]),
         .ovf     (pend_ovf[i])
      );
   end

   // first source with pending events, searching upward from the rr pointer
   always_comb begin
      cand_vld = 1'b0;
      cand     = '0;
      idx_w    = '0;
      for (int k = 0; k < NUM_STATS; k++) begin
         idx_w = {1'b0, rr_q} + (ADDR_W+1)'(k);
         if (idx_w >= (ADDR_W+1)'(NUM_STATS)) idx_w = idx_w - (ADDR_W+1)'(NUM_STATS);
         if (!cand_vld && (pend[idx_w[ADDR_W-1:0]] != '0)) begin
            cand_vld = 1'b1;
            cand     = idx_w[ADDR_W-1:0];
         end
      end
   end

   assign addr_ok = (gnt_addr_q < NUM_ADDR);
   assign mem_rd  = addr_ok ? mem_q[gnt_addr_q] : '0;

   // next-state, arbitration and array access control
   always_comb begin
      state_d      = state_q;
      gnt_src_d    = gnt_src_q;
      last_gnt_d   = last_gnt_q;
      gnt_addr_d   = gnt_addr_q;
      rr_d         = rr_q;
      init_cnt_d   = init_cnt_q;
      init_done_d  = init_done_q;
      snap_d       = snap_q;
      rd_d         = rd_q;
      host_rdata_d = host_rdata_q;
      gnt_vec      = '0;
      mem_we       = 1'b0;
      mem_addr     = gnt_addr_q;
      mem_wdata    = '0;
      host_ack_c   = 1'b0;
      host_win     = host.host_req && (!cand_vld || last_gnt_q == GNT_ENGINE);
      unique case (state_q)
         ST_INIT: begin
            mem_we   = 1'b1;
            mem_addr = init_cnt_q;
            if (init_cnt_q == LAST_ADDR) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else begin
               init_cnt_d = init_cnt_q + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            if (host_win) begin
               state_d    = ST_RD;
               gnt_src_d  = GNT_HOST;
               last_gnt_d = GNT_HOST;
               gnt_addr_d = host.host_addr;
            end else if (cand_vld) begin
               state_d       = ST_RD;
               gnt_src_d     = GNT_ENGINE;
               last_gnt_d    = GNT_ENGINE;
               gnt_addr_d    = cand;
               snap_d        = pend[cand];
               gnt_vec[cand] = 1'b1;
               rr_d          = (cand == LAST_ADDR) ? '0 : cand + ADDR_W'(1);
            end
         end
         ST_RD: begin
            state_d = ST_WR;
            rd_d    = mem_rd;
            if (gnt_src_q == GNT_HOST) host_rdata_d = mem_rd;
         end
         ST_WR: begin
            state_d = ST_IDLE;
            if (gnt_src_q == GNT_ENGINE) begin
               mem_we    = addr_ok;
               mem_wdata = rd_q + CNT_W'(snap_q);
            end else begin
               host_ack_c = 1'b1;
               mem_we     = addr_ok && host.host_clr;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // control and datapath registers
   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_INIT;
         gnt_src_q    <= GNT_ENGINE;
         last_gnt_q   <= GNT_ENGINE;
         gnt_addr_q   <= '0;
         rr_q         <= '0;
         init_cnt_q   <= '0;
         init_done_q  <= 1'b0;
         snap_q       <= '0;
         rd_q         <= '0;
         host_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         gnt_src_q    <= gnt_src_d;
         last_gnt_q   <= last_gnt_d;
         gnt_addr_q   <= gnt_addr_d;
         rr_q         <= rr_d;
         init_cnt_q   <= init_cnt_d;
         init_done_q  <= init_done_d;
         snap_q       <= snap_d;
         rd_q         <= rd_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   // counter array write port; contents are cleared by the INIT sweep, not by reset
   always_ff @(posedge rxclk) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
   end

   assign host.host_ack   = host_ack_c;
   assign host.host_rdata = host_rdata_q;
   assign init_done       = init_done_q;

endmodule

// File: tb/tb_rx_stat_scheduler.sv
// Directed bench for rx_stat_scheduler.
module tb_rx_stat_scheduler;
   import rx_stat_pkg::*;

   logic                 rxclk = 1'b0;
   logic                 reset_n;
   logic [NUM_STATS-1:0] stat_plus;
   logic [NUM_STATS-1:0] pend_ovf;
   logic                 init_done;

   rx_stat_scheduler_if host_if ();

   rx_stat_scheduler dut (
      .rxclk     (rxclk),
      .reset_n   (reset_n),
      .stat_plus (stat_plus),
      .host      (host_if),
      .pend_ovf  (pend_ovf),
      .init_done (init_done)
   );

   always #5 rxclk = ~rxclk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge rxclk);
      #1;
   endtask

   // request at posedge+1; lat counts falling edges up to and including the ack cycle
   task automatic host_read(input int addr, input logic clr, output logic [63:0] data, output int lat);
      logic got;
      got  = 1'b0;
      lat  = 0;
      data = '0;
      host_if.host_req  = 1'b1;
      host_if.host_addr = ADDR_W'(addr);
      host_if.host_clr  = clr;
      while (!got && lat < 60) begin
         @(negedge rxclk);
         lat++;
         if (host_if.host_ack) begin
            got  = 1'b1;
            data = host_if.host_rdata;
         end
      end
      chk("ack_seen", 64'(got), 64'd1);
      @(posedge rxclk);
      #1;
      host_if.host_req = 1'b0;
      host_if.host_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      int lat, m, g;
      logic [63:0] exp_v;

      reset_n           = 1'b0;
      stat_plus         = '0;
      host_if.host_req  = 1'b0;
      host_if.host_addr = '0;
      host_if.host_clr  = 1'b0;

      // reset values
      repeat (3) @(posedge rxclk);
      #1;
      chk("rst_init_done", 64'(init_done), 64'd0);
      chk("rst_ack", 64'(host_if.host_ack), 64'd0);
      chk("rst_rdata", host_if.host_rdata, 64'd0);
      chk("rst_ovf", 64'(pend_ovf), 64'd0);

      // test 1: init sweep then read all counters
      reset_n = 1'b1;
      cycles(17);
      chk("init_done_early", 64'(init_done), 64'd0);
      cycles(2);
      chk("init_done_set", 64'(init_done), 64'd1);
      for (int a = 0; a < NUM_STATS; a++) begin
         host_read(a, 1'b0, d, lat);
         chk("t1_rdata", d, 64'd0);
         chk("t1_latency", 64'(lat), 64'd3);
      end
      host_read(25, 1'b0, d, lat);
      chk("oor_rdata", d, 64'd0);
      chk("oor_latency", 64'(lat), 64'd3);

      // test 2: single pulse on source 3
      stat_plus[3] = 1'b1;
      cycles(1);
      stat_plus = '0;
      cycles(6);
      host_read(4, 1'b0, d, lat);
      chk("t2_cnt4", d, 64'd0);
      host_read(2, 1'b0, d, lat);
      chk("t2_cnt2", d, 64'd0);
      host_read(3, 1'b1, d, lat);
      chk("t2_cnt3", d, 64'd1);

      // test 3: 20 consecutive events on source 0
      stat_plus[0] = 1'b1;
      cycles(20);
      stat_plus = '0;
      cycles(30);
      host_read(0, 1'b1, d, lat);
      chk("t3_cnt0", d, 64'd20);
      chk("t3_ovf", 64'(pend_ovf), 64'd0);

      // test 4: all sources for 30 cycles; rr starts at 1, slot m grants source m+1 at cycle 1+3m
      stat_plus = '1;
      cycles(30);
      stat_plus = '0;
      cycles(120);
      chk("t4_ovf", 64'(pend_ovf), 64'h3FFFF);
      for (int s = 0; s < NUM_STATS; s++) begin
         m = (s + NUM_STATS - 1) % NUM_STATS;
         g = 1 + 3 * m;
         if (g <= 15)     exp_v = 64'(g + 15);
         else if (g < 30) exp_v = 64'(45 - g);
         else             exp_v = 64'd15;
         host_read(s, 1'b1, d, lat);
         chk("t4_cnt", d, exp_v);
         chk("t4_latency", 64'(lat), 64'd3);
      end

      // test 5: clear-on-read of counter 7 with an event arriving during RD
      stat_plus[7] = 1'b1;
      cycles(5);
      stat_plus = '0;
      cycles(20);
      host_if.host_req  = 1'b1;
      host_if.host_addr = 5'd7;
      host_if.host_clr  = 1'b1;
      @(posedge rxclk); #1;
      stat_plus[7] = 1'b1;
      @(posedge rxclk); #1;
      stat_plus = '0;
      @(negedge rxclk);
      chk("t5_ack", 64'(host_if.host_ack), 64'd1);
      chk("t5_rdata", host_if.host_rdata, 64'd5);
      @(posedge rxclk); #1;
      host_if.host_req = 1'b0;
      host_if.host_clr = 1'b0;
      cycles(10);
      host_read(7, 1'b0, d, lat);
      chk("t5_reread", d, 64'd1);

      // test 6: host held against a busy source alternates slots
      host_if.host_req  = 1'b1;
      host_if.host_addr = 5'd2;
      host_if.host_clr  = 1'b0;
      stat_plus[2]      = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge rxclk);
         chk("t6_ack_slot", 64'(host_if.host_ack), 64'((k % 6) == 2));
      end
      @(posedge rxclk);
      @(posedge rxclk); #1;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_ack", 64'(host_if.host_ack), 64'd0);
      chk("t6_rst_rdata", host_if.host_rdata, 64'd0);
      chk("t6_rst_init_done", 64'(init_done), 64'd0);
      chk("t6_rst_ovf", 64'(pend_ovf), 64'd0);
      @(negedge rxclk);
      chk("t6_rst_no_ack", 64'(host_if.host_ack), 64'd0);
      stat_plus        = '0;
      host_if.host_req = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      cycles(25);
      chk("t6_reinit_done", 64'(init_done), 64'd1);
      host_read(2, 1'b0, d, lat);
      chk("t6_reinit_cnt2", d, 64'd0);
      chk("t6_reinit_latency", 64'(lat), 64'd3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
